exe_stage: RTL
==============

# exe_stage

Execute stage of the five-stage ARM pipeline. It consumes the ID/EX pipeline register outputs and evaluates the operand-2 generator and the ALU. It owns the NZCV status register and registers results into the EX/MEM boundary. It returns the branch target, the branch-taken indication and the current flags to the fetch and decode stages.

## Interface
Parameters: none.
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- freeze  input  1  memory-stage stall; holds EX/MEM register and status register
- wb_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in  input  1 each  control bits from ID/EX
- exe_cmd_in  input  4  ALU operation
- PC_in  input  32  PC+4 of instruction in EX
- val_Rn_in, val_Rm_in  input  32  register operands
- shift_operand_in  input  12  operand-2 field
- signed_imm_24_in  input  24  branch offset (words)
- dest_in  input  4  destination register
- branch_taken  output  1  combinational, equals B_in
- branch_addr  output  32  combinational, PC_in + (sign_extend(signed_imm_24_in) << 2)
- SR  output  4  status register {N,Z,C,V}, registered
- wb_en, mem_read, mem_write  output  1 each  registered EX/MEM controls
- alu_res  output  32  registered ALU result / memory address
- val_Rm  output  32  registered store data
- dest  output  4  registered destination

## Operation
- Val2 generator, priority order:
  - mem_read_in or mem_write_in: zero-extend shift_operand_in[11:0].
  - Else imm_in: {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
  - Else: val_Rm_in shifted by shift_operand_in[11:7], type shift_operand_in[6:5]. 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 passes val_Rm_in unchanged.
- ALU, exe_cmd_in encodings (all 32-bit, wrap-around):
  - 0001 MOV = val2.
  - 1001 MVN = ~val2.
  - 0010 ADD = Rn+val2.
  - 0011 ADC = Rn+val2+C.
  - 0100 SUB/CMP = Rn-val2.
  - 0101 SBC = Rn-val2-(~C).
  - 0110 AND/TST = Rn&val2.
  - 0111 ORR = Rn|val2.
  - 1000 EOR = Rn^val2.
  - Any other code: result 0, flags untouched.
  - LDR/STR use 0010.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add ops: C = bit 32 of 33-bit sum; V = (a[31]==b[31]) && (res[31]!=a[31]).
  - Subtract ops: C = 1 when no borrow (unsigned Rn >= subtrahend, borrow-in included); V = (a[31]!=b[31]) && (res[31]!=a[31]).
  - MOV, MVN and logical ops update N and Z only; C and V keep their prior value.
- Status register: loads the new flags on a rising edge when S_in=1 and freeze=0. Otherwise it holds. The C used by ADC/SBC is the registered C.
- EX/MEM register: on a rising edge with freeze=0 it captures wb_en_in, mem_read_in, mem_write_in, the ALU result, val_Rm_in and dest_in. With freeze=1 every registered output holds.
- No flush input. Branch squashing is done upstream by the ID/EX register on branch_taken.

## Timing
- rst low, at any time including mid-stall: SR=0; wb_en, mem_read, mem_write=0; alu_res, val_Rm=0; dest=0. Takes effect immediately and is asynchronous. While rst is low the inputs are ignored.
- The first capture is on the first rising edge after rst goes high.
- Latency: one cycle from ID/EX inputs to EX/MEM outputs. SR reflects an S-instruction one cycle later, in time for the condition check of the next instruction in ID.
- branch_taken and branch_addr are purely combinational and have zero latency.
- freeze=1 together with S_in=1: the flags are not updated. An instruction held by the stall updates the flags exactly once, on the edge where freeze=0.
- Back-to-back ADC after ADDS uses the C produced by ADDS, because it is registered between them.

## Test plan
- Reset: drive arbitrary inputs and pulse rst low mid-cycle -> all outputs 0 immediately; outputs stay 0 until the first edge after release.
- ADDS: Rn=0x7FFFFFFF, imm 0x01 rot 0, cmd 0010, S=1 -> alu_res=0x80000000, SR=1001 (N,V) next cycle.
- SUBS then SBC: Rn=5, val2=5 (cmd 0100, S=1) -> Z=1, C=1. Then SBC Rn=10, val2=3 -> alu_res=7.
- Val2 paths:
  - imm 0xFF with rot 4 -> val2=0xFF000000.
  - Rm=0x80000000 with ASR #4 -> 0xF8000000.
  - mem_read with field 0x804 -> address Rn+0x804.
- Freeze: hold freeze=1 for 3 cycles while the inputs change and S=1 -> outputs and SR frozen. Release -> the current inputs are captured and SR is updated once.
- Branch: PC_in=0x100, imm24=0xFFFFFE, B=1 -> branch_addr=0xF8, branch_taken=1 in the same cycle.

Source files
------------

// File: rtl/exe_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The master side is the decode/ID-EX register; the slave side is exe_stage.
interface exe_stage_if;
  // ID/EX pipeline register outputs
  logic        wb_en_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        B_in;
  logic        S_in;
  logic        imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] PC_in;
  logic [31:0] val_Rn_in;
  logic [31:0] val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;

  // returned to fetch / decode
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  SR;

  // EX/MEM pipeline register outputs
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_res;
  logic [31:0] val_Rm;
  logic [3:0]  dest;

  modport master (
    output wb_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in,
           exe_cmd_in, PC_in, val_Rn_in, val_Rm_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    input  branch_taken, branch_addr, SR,
           wb_en, mem_read, mem_write, alu_res, val_Rm, dest
  );

  modport slave (
    input  wb_en_in, mem_read_in, mem_write_in, B_in, S_in, imm_in,
           exe_cmd_in, PC_in, val_Rn_in, val_Rm_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    output branch_taken, branch_addr, SR,
           wb_en, mem_read, mem_write, alu_res, val_Rm, dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage of the five-stage ARM pipeline: operand-2 generator, ALU,
// NZCV status register and the EX/MEM pipeline register.
module exe_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  exe_stage_if.slave bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] shift_rm(input logic [31:0] rm,
                                           input logic [4:0]  amt,
                                           input logic [1:0]  kind);
    logic signed [31:0] rm_s;
    logic        [31:0] res;
    rm_s = rm;
    case (kind)
      SH_LSL:  res = rm << amt;
      SH_LSR:  res = rm >> amt;
      SH_ASR:  res = rm_s >>> amt;
      SH_ROR:  res = ror32(rm, amt);
      default: res = rm;
    endcase
    return res;
  endfunction

  // Address offsets win over immediates so LDR/STR always see the raw 12-bit field.
  function automatic logic [31:0] gen_val2(input logic        mem_acc,
                                           input logic        imm,
                                           input logic [11:0] so,
                                           input logic [31:0] rm);
    logic [31:0] res;
    if (mem_acc)
      res = {20'b0, so};
    else if (imm)
      res = ror32({24'b0, so[7:0]}, {so[11:8], 1'b0});
    else
      res = shift_rm(rm, so[11:7], so[6:5]);
    return res;
  endfunction

  function automatic logic [32:0] add33(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        cin);
    return {1'b0, a} + {1'b0, b} + {32'b0, cin};
  endfunction

  // Signed overflow when both addends share a sign the sum does not.
  function automatic logic add_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  // Registered state
  logic        wb_en_q,     wb_en_d;
  logic        mem_read_q,  mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] alu_res_q,   alu_res_d;
  logic [31:0] val_rm_q,    val_rm_d;
  logic [3:0]  dest_q,      dest_d;
  logic [3:0]  sr_q,        sr_d;

  // Combinational ALU signals
  logic [31:0] val2;
  logic [31:0] alu_out;
  logic [32:0] sum33;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cmd_valid;
  logic        carry_q;

  assign carry_q = sr_q[1];

  always_comb begin
    val2 = gen_val2(bus.mem_read_in | bus.mem_write_in, bus.imm_in,
                    bus.shift_operand_in, bus.val_Rm_in);
  end

  // Subtraction is a + ~b + carry-in so C reads as "no borrow" directly.
  always_comb begin
    alu_out   = '0;
    sum33     = '0;
    flag_c    = carry_q;
    flag_v    = sr_q[0];
    cmd_valid = 1'b1;
    case (bus.exe_cmd_in)
      CMD_MOV: alu_out = val2;
      CMD_MVN: alu_out = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum33   = add33(bus.val_Rn_in, val2,
                        (bus.exe_cmd_in == CMD_ADC) ? carry_q : 1'b0);
        alu_out = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = add_ovf(bus.val_Rn_in, val2, sum33[31:0]);
      end
      CMD_SUB, CMD_SBC: begin
        sum33   = add33(bus.val_Rn_in, ~val2,
                        (bus.exe_cmd_in == CMD_SBC) ? carry_q : 1'b1);
        alu_out = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = add_ovf(bus.val_Rn_in, ~val2, sum33[31:0]);
      end
      CMD_AND: alu_out = bus.val_Rn_in & val2;
      CMD_ORR: alu_out = bus.val_Rn_in | val2;
      CMD_EOR: alu_out = bus.val_Rn_in ^ val2;
      default: cmd_valid = 1'b0;
    endcase
    flag_n = alu_out[31];
    flag_z = (alu_out == 32'b0);
  end

  always_comb begin
    wb_en_d     = wb_en_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_res_d   = alu_res_q;
    val_rm_d    = val_rm_q;
    dest_d      = dest_q;
    sr_d        = sr_q;
    if (!freeze) begin
      wb_en_d     = bus.wb_en_in;
      mem_read_d  = bus.mem_read_in;
      mem_write_d = bus.mem_write_in;
      alu_res_d   = alu_out;
      val_rm_d    = bus.val_Rm_in;
      dest_d      = bus.dest_in;
      if (bus.S_in && cmd_valid)
        sr_d = {flag_n, flag_z, flag_c, flag_v};
    end
  end

  // EX/MEM boundary and status register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_res_q   <= '0;
      val_rm_q    <= '0;
      dest_q      <= '0;
      sr_q        <= '0;
    end else begin
      wb_en_q     <= wb_en_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_res_q   <= alu_res_d;
      val_rm_q    <= val_rm_d;
      dest_q      <= dest_d;
      sr_q        <= sr_d;
    end
  end

  assign bus.branch_taken = bus.B_in;
  assign bus.branch_addr  = bus.PC_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};
  assign bus.SR           = sr_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.alu_res      = alu_res_q;
  assign bus.val_Rm       = val_rm_q;
  assign bus.dest         = dest_q;

endmodule
